// File: rtl/adder_exhaustive_checker.sv
// Exhaustive stimulus-and-check stage for a WIDTH-bit carry-in adder.
// Sweeps every {A, B, C0}, waits SETTLE_CYCLES, then counts {C4, S} mismatches.
module adder_exhaustive_checker #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   A_out,
    output logic [WIDTH-1:0]   B_out,
    output logic               C0_out,
    input  logic               dut_C4,
    input  logic [WIDTH-1:0]   dut_S,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH+1:0] err_count,
    output logic [2*WIDTH:0]   first_fail_idx,
    output logic               first_fail_vld
);

    localparam int unsigned IW = 2 * WIDTH + 1;
    localparam int unsigned CW = IW + 1;
    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck,
        StDone
    } state_e;

    state_e          state;
    logic [IW-1:0]   idx;
    logic [SW-1:0]   settle_cnt;
    logic [WIDTH:0]  golden;
    logic            mismatch;
    logic            idx_last;

    // Operands come straight from the registered vector index.
    assign A_out  = idx[IW-1:WIDTH+1];
    assign B_out  = idx[WIDTH:1];
    assign C0_out = idx[0];

    assign golden   = {1'b0, A_out} + {1'b0, B_out} + {{WIDTH{1'b0}}, C0_out};
    assign mismatch = ({dut_C4, dut_S} != golden);
    assign idx_last = (idx == {IW{1'b1}});
    assign pass     = done && (err_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= StIdle;
            idx            <= '0;
            settle_cnt     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        err_count      <= '0;
                        first_fail_idx <= '0;
                        first_fail_vld <= 1'b0;
                        idx            <= '0;
                        settle_cnt     <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        state          <= StSettle;
                    end
                end
                StSettle: begin
                    settle_cnt <= settle_cnt + SW'(1);
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= StCheck;
                    end
                end
                StCheck: begin
                    if (mismatch) begin
                        err_count <= err_count + CW'(1);
                        if (!first_fail_vld) begin
                            first_fail_idx <= idx;
                            first_fail_vld <= 1'b1;
                        end
                    end
                    if (idx_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        idx        <= idx + IW'(1);
                        settle_cnt <= '0;
                        state      <= StSettle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
